// File: rtl/ahb_matrix_param.sv
// AHB-Lite single-master interconnect with base/mask decode, a built-in default
// slave, and a per-transfer stall watchdog with error status outputs.
module ahb_matrix_param #(
    parameter int                      SLV_COUNT = 4,
    parameter logic [32*SLV_COUNT-1:0] SLV_BASE  = {32'h0003_0000, 32'h0002_0000,
                                                    32'h0001_0000, 32'h0000_0000},
    parameter logic [32*SLV_COUNT-1:0] SLV_MASK  = {4{32'hFFFF_0000}},
    parameter int                      TIMEOUT   = 255,
    parameter int                      CNT_W     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [1:0]                HTRANS,
    input  logic [31:0]               HADDR,
    output logic [31:0]               HRDATA,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [SLV_COUNT-1:0]      S_HSEL,
    input  logic [32*SLV_COUNT-1:0]   S_HRDATA,
    input  logic [SLV_COUNT-1:0]      S_HREADYOUT,
    input  logic [SLV_COUNT-1:0]      S_HRESP,
    output logic                      err_unmapped,
    output logic                      err_timeout,
    output logic [3:0]                err_slave,
    output logic [CNT_W-1:0]          err_count
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {PASS, ERR1, ERR2} state_t;

    state_t               state, nxt;
    logic [SLV_COUNT-1:0] sel_r;
    logic                 dflt_r;
    logic                 hit, dflt;
    logic [WD_W-1:0]      wd_cnt;
    logic [31:0]          mux_data;
    logic                 mux_rdy, mux_resp;
    logic [3:0]           sel_idx;
    logic                 expire;

    // Lowest matching index wins on overlap.
    always_comb begin
        S_HSEL = '0;
        hit    = 1'b0;
        for (int i = 0; i < SLV_COUNT; i++) begin
            if (!hit && ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                S_HSEL[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    assign dflt = !hit && (HTRANS == 2'b10 || HTRANS == 2'b11);

    always_comb begin
        mux_data = '0;
        mux_rdy  = 1'b1;
        mux_resp = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < SLV_COUNT; i++) begin
            if (sel_r[i]) begin
                mux_data = S_HRDATA[32*i +: 32];
                mux_rdy  = S_HREADYOUT[i];
                mux_resp = S_HRESP[i];
                sel_idx  = 4'(i);
            end
        end
    end

    assign expire = (TIMEOUT != 0) && (state == PASS) && (|sel_r) && !mux_rdy
                    && (wd_cnt == WD_LAST);

    // The unmapped error enters ERR1 on the same edge that loads dflt_r, so the
    // data phase is exactly ERR1 then ERR2.
    always_comb begin
        nxt    = state;
        HRDATA = '0;
        HRESP  = 1'b0;
        HREADY = 1'b1;
        unique case (state)
            PASS: begin
                HRDATA = mux_data;
                HRESP  = mux_resp;
                HREADY = mux_rdy;
                if ((mux_rdy && dflt) || expire)
                    nxt = ERR1;
            end
            ERR1: begin
                HRESP  = 1'b1;
                HREADY = 1'b0;
                nxt    = ERR2;
            end
            ERR2: begin
                HRESP = 1'b1;
                nxt   = dflt ? ERR1 : PASS;
            end
            default: nxt = PASS;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= PASS;
            sel_r     <= '0;
            dflt_r    <= 1'b0;
            wd_cnt    <= '0;
            err_slave <= '0;
            err_count <= '0;
        end else begin
            state <= nxt;
            if (HREADY) begin
                sel_r  <= S_HSEL;
                dflt_r <= dflt;
                wd_cnt <= '0;
            end else if (state == PASS && (|sel_r) && !mux_rdy) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (expire)
                err_slave <= sel_idx;
            if (state == ERR2 && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

    // dflt_r stays set through ERR1/ERR2 only for the unmapped case.
    assign err_unmapped = (state == ERR2) && dflt_r;
    assign err_timeout  = (state == ERR2) && !dflt_r;

endmodule

// File: tb/tb_ahb_matrix_param.sv
// Directed bench for ahb_matrix_param: per-cycle expected data-phase responses are
// queued when each address phase is driven and checked when their cycle comes up.
module tb_ahb_matrix_param;

    localparam logic [31:0] IDLE_A = 32'h0009_0000;
    localparam logic [31:0] UA     = 32'h0009_0000;

    logic         HCLK, HRESET;
    logic [1:0]   HTRANS;
    logic [31:0]  HADDR, HRDATA;
    logic         HREADY, HRESP;
    logic [3:0]   S_HSEL;
    logic [127:0] S_HRDATA;
    logic [3:0]   S_HREADYOUT, S_HRESP;
    logic         err_unmapped, err_timeout;
    logic [3:0]   err_slave;
    logic [7:0]   err_count;

    ahb_matrix_param #(.TIMEOUT(4), .CNT_W(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HADDR(HADDR),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .S_HSEL(S_HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .err_unmapped(err_unmapped), .err_timeout(err_timeout),
        .err_slave(err_slave), .err_count(err_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        logic        rdy;
        logic        eu;
        logic        et;
        int          due;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_chk;
    int         n_fail;
    logic [7:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push(input int off, input logic [31:0] d, input logic r, input logic y,
                        input logic eu, input logic et);
        exp_t e;
        e.rdata = d; e.resp = r; e.rdy = y; e.eu = eu; e.et = et; e.due = cyc + off;
        sb.push_back(e);
    endtask

    // One bus cycle: drive address phase, check at negedge, advance to posedge+1.
    task automatic step(input logic [1:0] tr, input logic [31:0] a, input logic [3:0] esel);
        exp_t e;
        logic inc;
        inc    = 1'b0;
        HTRANS = tr;
        HADDR  = a;
        @(negedge HCLK);
        check("hsel", 32'(S_HSEL), 32'(esel));
        check("err_count", 32'(err_count), 32'(exp_cnt));
        while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("hrdata", HRDATA, e.rdata);
            check("hresp", 32'(HRESP), 32'(e.resp));
            check("hready", 32'(HREADY), 32'(e.rdy));
            check("err_unmapped", 32'(err_unmapped), 32'(e.eu));
            check("err_timeout", 32'(err_timeout), 32'(e.et));
            if (e.eu || e.et) inc = 1'b1;
        end
        @(posedge HCLK);
        if (HRESET) exp_cnt = 8'd0;
        else if (inc && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        #1;
        cyc++;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; exp_cnt = 8'd0;
        HRESET = 1'b1; HTRANS = 2'b00; HADDR = IDLE_A;
        S_HRDATA    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};
        S_HREADYOUT = 4'hF;
        S_HRESP     = 4'h0;
        repeat (2) @(posedge HCLK);
        #1;

        // Reset state
        push(0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b00, IDLE_A, 4'b0000);
        check("err_slave_reset", 32'(err_slave), 32'd0);
        HRESET = 1'b0;

        // Mapped NONSEQ read to slave1, zero wait
        push(1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b10, 32'h0001_0004, 4'b0010);
        // SEQ to slave0, then idle
        push(1, 32'h1111_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b11, 32'h0000_0100, 4'b0001);
        step(2'b00, IDLE_A, 4'b0000);

        // Unmapped NONSEQ: two-cycle ERROR, then IDLE to the same address is OKAY
        push(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(2'b10, UA, 4'b0000);
        step(2'b00, IDLE_A, 4'b0000);
        push(1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b00, IDLE_A, 4'b0000);
        step(2'b00, IDLE_A, 4'b0000);
        check("err_count_one", 32'(err_count), 32'd1);

        // Watchdog: slave2 stalls, abort after 4 stall cycles
        S_HREADYOUT = 4'b1011;
        for (int k = 1; k <= 4; k++) push(k, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
        push(5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(6, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(2'b10, 32'h0002_0000, 4'b0100);
        repeat (6) step(2'b00, IDLE_A, 4'b0000);
        S_HREADYOUT = 4'hF;
        check("err_slave_timeout", 32'(err_slave), 32'd2);

        // Slave-originated ERROR passes through and is not counted
        S_HRESP = 4'b1000;
        push(1, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 1'b0);
        step(2'b10, 32'h0003_0010, 4'b1000);
        step(2'b00, IDLE_A, 4'b0000);
        S_HRESP = 4'h0;
        check("err_count_two", 32'(err_count), 32'd2);

        // 300 back-to-back unmapped NONSEQs, counter saturates
        for (int i = 0; i < 300; i++) begin
            push(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
            push(2, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
            step(2'b10, UA, 4'b0000);
            step(2'b10, UA, 4'b0000);
        end
        push(1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b00, IDLE_A, 4'b0000);
        step(2'b00, IDLE_A, 4'b0000);
        check("err_count_sat", 32'(err_count), 32'd255);

        // Reset asserted during ERR1
        push(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b10, UA, 4'b0000);
        HRESET = 1'b1;
        step(2'b00, IDLE_A, 4'b0000);
        HRESET = 1'b0;
        push(0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b00, IDLE_A, 4'b0000);
        check("err_slave_rst2", 32'(err_slave), 32'd0);
        check("err_count_rst2", 32'(err_count), 32'd0);
        push(1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b10, 32'h0001_0004, 4'b0010);
        step(2'b00, IDLE_A, 4'b0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
